// File: rtl/video_gen_pkg.sv
// Shared types and constants for the synthetic video source: FSM states,
// pattern codes and counter widths.
package video_gen_pkg;

  localparam int X_W    = 10;
  localparam int LINE_W = 9;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBACK  = 3'd2,
    ACTIVE = 3'd3,
    VFRONT = 3'd4
  } state_e;

  localparam logic [1:0] PAT_HRAMP = 2'd0;
  localparam logic [1:0] PAT_VRAMP = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_INC   = 2'd3;

  function automatic logic [7:0] checker_pix(input logic xb, input logic yb);
    return (xb ^ yb) ? 8'hFF : 8'h00;
  endfunction

endpackage

// File: rtl/video_stream_gen_lut.sv
// Combinational test-pattern lookup: (x, y, index, sel) -> pixel.
// Optional VIDEO_GEN_BORDER_EN forces a full-white one-pixel frame border.
module video_pattern_lut
  import video_gen_pkg::*;
#(
  parameter logic [8:0] IMG_HDISP = 9'd320,
  parameter logic [7:0] IMG_VDISP = 8'd240
) (
  input  logic [X_W-1:0]    x_i,
  input  logic [LINE_W-1:0] y_i,
  input  logic [7:0]        idx_i,
  input  logic [1:0]        sel_i,
  output logic [7:0]        pix_o
);

`ifdef VIDEO_GEN_BORDER_EN
  localparam logic [X_W-1:0]    X_LAST = X_W'(IMG_HDISP - 9'd1);
  localparam logic [LINE_W-1:0] Y_LAST = LINE_W'(IMG_VDISP - 8'd1);
`endif

  // Upper coordinate bits only matter for the border compare.
  logic unused_hi;
  assign unused_hi = ^{x_i[X_W-1:8], y_i[LINE_W-1:8]};

  always_comb begin
    pix_o = 8'h00;
    case (sel_i)
      PAT_HRAMP: pix_o = x_i[7:0];
      PAT_VRAMP: pix_o = y_i[7:0];
      PAT_CHECK: pix_o = checker_pix(x_i[3], y_i[3]);
      PAT_INC:   pix_o = idx_i;
      default:   pix_o = 8'h00;
    endcase
`ifdef VIDEO_GEN_BORDER_EN
    if (x_i == '0 || x_i == X_LAST || y_i == '0 || y_i == Y_LAST) begin
      pix_o = 8'hFF;
    end
`endif
  end

endmodule

// File: rtl/video_stream_gen.sv
// Synthetic video source: blanking/sync timing FSM, clock-enable pacing and
// selectable test patterns. Build with VIDEO_GEN_BORDER_EN for a white border.
module video_stream_gen
  import video_gen_pkg::*;
#(
  parameter logic [8:0] IMG_HDISP = 9'd320,
  parameter logic [7:0] IMG_VDISP = 8'd240,
  parameter logic [9:0] H_BLANK   = 10'd40,
  parameter logic [3:0] VSYNC_LEN = 4'd2,
  parameter logic [3:0] V_BACK    = 4'd2,
  parameter logic [3:0] V_FRONT   = 4'd2,
  parameter logic [3:0] CLKEN_DIV = 4'd1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic [7:0] post_img,
  output logic       frame_done
);

  localparam logic [X_W-1:0] HDISP_X  = X_W'(IMG_HDISP);
  localparam logic [X_W-1:0] X_LAST   = HDISP_X + X_W'(H_BLANK) - X_W'(1);
  localparam logic [3:0]     DIV_LAST = (CLKEN_DIV == 4'd0) ? 4'd0 : CLKEN_DIV - 4'd1;
  localparam logic [7:0]     HDISP_LO = IMG_HDISP[7:0];

  state_e              state_q, state_d;
  logic [3:0]          div_q, div_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [1:0]          sel_q, sel_d;
  logic                vsync_q, vsync_d, href_q, href_d, clken_q, clken_d, done_q, done_d;
  logic [7:0]          img_q, img_d, pix, idx;
  logic                running, tick, slot_end, line_end, state_end, frame_end, pix_on;
  state_e              next_live;

  function automatic logic [LINE_W-1:0] state_len(input state_e s);
    case (s)
      VSYNC:   return LINE_W'(VSYNC_LEN);
      VBACK:   return LINE_W'(V_BACK);
      ACTIVE:  return LINE_W'(IMG_VDISP);
      VFRONT:  return LINE_W'(V_FRONT);
      default: return '0;
    endcase
  endfunction

  // First state at or after 'from' that has a non-zero line count; IDLE means
  // the frame has no states left.
  function automatic state_e first_live(input state_e from);
    state_e s;
    s = IDLE;
    if (from <= VFRONT && V_FRONT   != 4'd0) s = VFRONT;
    if (from <= ACTIVE && IMG_VDISP != 8'd0) s = ACTIVE;
    if (from <= VBACK  && V_BACK    != 4'd0) s = VBACK;
    if (from <= VSYNC  && VSYNC_LEN != 4'd0) s = VSYNC;
    return s;
  endfunction

  assign running   = (state_q != IDLE);
  assign tick      = running && (div_q == 4'd0);
  assign slot_end  = running && (div_q == DIV_LAST);
  assign line_end  = slot_end && (x_q == X_LAST);
  assign state_end = line_end && (line_q == state_len(state_q) - LINE_W'(1));
  assign next_live = first_live(state_e'(state_q + 3'd1));
  assign idx       = line_q[7:0] * HDISP_LO + x_q[7:0];

  video_pattern_lut #(
    .IMG_HDISP(IMG_HDISP),
    .IMG_VDISP(IMG_VDISP)
  ) u_lut (
    .x_i  (x_q),
    .y_i  (line_q),
    .idx_i(idx),
    .sel_i(sel_q),
    .pix_o(pix)
  );

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    x_d       = x_q;
    line_d    = line_q;
    sel_d     = sel_q;
    frame_end = 1'b0;
    if (!running) begin
      div_d  = 4'd0;
      x_d    = '0;
      line_d = '0;
      if (enable) begin
        state_d = first_live(VSYNC);
        sel_d   = pattern_sel;
      end
    end else begin
      div_d = slot_end ? 4'd0 : div_q + 4'd1;
      if (slot_end) x_d = line_end ? '0 : x_q + X_W'(1);
      if (line_end) line_d = state_end ? '0 : line_q + LINE_W'(1);
      if (state_end) begin
        if (next_live != IDLE) begin
          state_d = next_live;
        end else begin
          frame_end = 1'b1;
          if (enable) begin
            state_d = first_live(VSYNC);
            sel_d   = pattern_sel;
          end else begin
            state_d = IDLE;
          end
        end
      end
    end
  end

  // Output stage: everything reflects the slot one cycle later.
  always_comb begin
    pix_on  = (state_q == ACTIVE) && (x_q < HDISP_X);
    vsync_d = (state_q == VSYNC);
    href_d  = pix_on;
    clken_d = pix_on && tick;
    done_d  = frame_end;
    img_d   = '0;
    if (clken_d)     img_d = pix;
    else if (pix_on) img_d = img_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      x_q     <= '0;
      line_q  <= '0;
      sel_q   <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      clken_q <= 1'b0;
      done_q  <= 1'b0;
      img_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      x_q     <= x_d;
      line_q  <= line_d;
      sel_q   <= sel_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      clken_q <= clken_d;
      done_q  <= done_d;
      img_q   <= img_d;
    end
  end

  assign post_frame_vsync = vsync_q;
  assign post_frame_href  = href_q;
  assign post_frame_clken = clken_q;
  assign post_img         = img_q;
  assign frame_done       = done_q;

endmodule

// File: tb/tb_video_stream_gen.sv
// Scoreboard bench for video_stream_gen: three instances (8x4 continuous,
// 8x4 paced by 3, 16x4 continuous) share stimulus; randomized pattern_sel.
module tb_video_stream_gen;

  localparam int NDUT = 3;
  localparam int VD   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic       vsO[NDUT], hrefO[NDUT], clkenO[NDUT], doneO[NDUT];
  logic [7:0] imgO[NDUT];

  int passCount = 0;
  int checkCount = 0;
  int cycle = 0;
  logic [1:0] selPrev1 = 2'd0, selPrev2 = 2'd0;
  int vsRiseCnt[NDUT], doneCnt[NDUT], lineCnt[NDUT];

  always #5 clk = ~clk;

  // Cycle index and the pattern_sel value present at each of the last two edges
  always @(posedge clk) begin
    cycle    <= cycle + 1;
    selPrev1 <= pattern_sel;
    selPrev2 <= selPrev1;
  end

  initial begin
    forever begin
      @(negedge clk);
      pattern_sel = 2'($urandom_range(0, 3));
    end
  end

  task automatic checkOutput(input string name, input int dut, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s (dut%0d): got %0d, expected %0d", name, dut, actual, expected);
  endtask

  // Reference pixel straight from the pattern definitions
  function automatic int refPixel(input int sel, input int x, input int y, input int hd);
    int v;
    case (sel)
      0:       v = x % 256;
      1:       v = y % 256;
      2:       v = (((x / 8) % 2) != ((y / 8) % 2)) ? 255 : 0;
      default: v = (y * hd + x) % 256;
    endcase
`ifdef VIDEO_GEN_BORDER_EN
    if (x == 0 || x == hd - 1 || y == 0 || y == VD - 1) v = 255;
`endif
    return v;
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : gen
    localparam int HD    = (g == 2) ? 16 : 8;
    localparam int DIV   = (g == 1) ? 3 : 1;
    localparam int LP    = HD + 4;
    localparam int FRAME = (1 + 1 + VD + 1) * LP * DIV;

    video_stream_gen #(
      .IMG_HDISP(9'(HD)),
      .IMG_VDISP(8'(VD)),
      .H_BLANK  (10'd4),
      .VSYNC_LEN(4'd1),
      .V_BACK   (4'd1),
      .V_FRONT  (4'd1),
      .CLKEN_DIV(4'(DIV))
    ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .enable          (enable),
      .pattern_sel     (pattern_sel),
      .post_frame_vsync(vsO[g]),
      .post_frame_href (hrefO[g]),
      .post_frame_clken(clkenO[g]),
      .post_img        (imgO[g]),
      .frame_done      (doneO[g])
    );

    int expQ[$];
    logic pvs, phref, pdone;
    int vsRun, hrefRun, lastVsRise, lastHrefRise, lastDone, lines;
    bit haveRise, haveDone;
    logic [7:0] lastImg;

    initial begin
      vsRiseCnt[g] = 0;
      doneCnt[g] = 0;
      lineCnt[g] = 0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          expQ.delete();
          pvs = 0; phref = 0; pdone = 0;
          vsRun = 0; hrefRun = 0; lines = 0; lineCnt[g] = 0;
          haveRise = 0; haveDone = 0; lastImg = 8'h00;
        end else begin
          if (vsO[g] && !pvs) begin
            if (haveRise && haveDone && lastDone == cycle - 1)
              checkOutput("frame period", g, cycle - lastVsRise, FRAME);
            lastVsRise = cycle; haveRise = 1; lines = 0; lineCnt[g] = 0;
            vsRiseCnt[g]++;
            vsRun = 0;
            expQ.delete();
            for (int y = 0; y < VD; y++)
              for (int x = 0; x < HD; x++)
                expQ.push_back(refPixel(int'(selPrev2), x, y, HD));
          end
          if (vsO[g]) vsRun++;
          if (!vsO[g] && pvs) checkOutput("vsync length", g, vsRun, LP * DIV);

          if (hrefO[g] && !phref) begin
            lines++; lineCnt[g] = lines;
            if (lines == 1 && haveRise) checkOutput("first href offset", g, cycle - lastVsRise, 2 * LP * DIV);
            else if (lines > 1) checkOutput("href period", g, cycle - lastHrefRise, LP * DIV);
            lastHrefRise = cycle; hrefRun = 0;
          end
          if (!hrefO[g] && phref) checkOutput("href length", g, hrefRun, HD * DIV);

          checkOutput("clken", g, clkenO[g], int'(hrefO[g] && (hrefRun % DIV == 0)));
          if (clkenO[g]) begin
            checkOutput("pixel available", g, int'(expQ.size() > 0), 1);
            if (expQ.size() > 0) checkOutput("pixel", g, imgO[g], expQ.pop_front());
          end else if (hrefO[g]) begin
            checkOutput("img hold", g, imgO[g], lastImg);
          end else begin
            checkOutput("img idle", g, imgO[g], 0);
          end
          lastImg = imgO[g];
          if (hrefO[g]) hrefRun++;

          if (doneO[g]) begin
            checkOutput("done pulse width", g, pdone, 0);
            if (haveRise) checkOutput("done offset", g, cycle - lastVsRise, FRAME - 1);
            checkOutput("lines per frame", g, lines, VD);
            checkOutput("pixels left", g, expQ.size(), 0);
            lastDone = cycle; haveDone = 1;
            doneCnt[g]++;
          end
          pvs = vsO[g]; phref = hrefO[g]; pdone = doneO[g];
        end
      end
    end
  end

  task automatic checkAllZero(input string tag);
    for (int g = 0; g < NDUT; g++) begin
      checkOutput({tag, " vsync"}, g, vsO[g], 0);
      checkOutput({tag, " href"},  g, hrefO[g], 0);
      checkOutput({tag, " clken"}, g, clkenO[g], 0);
      checkOutput({tag, " img"},   g, imgO[g], 0);
      checkOutput({tag, " done"},  g, doneO[g], 0);
    end
  endtask

  task automatic applyStimulus();
    int found;
    int d0, d1;
    int snapVs[NDUT], snapDone[NDUT];

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    enable = 1'b1;
    repeat (1300) @(negedge clk);

    // Drop enable inside line 2 of dut0; the frame must still finish
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (lineCnt[0] == 3 && hrefO[0]) begin found = 1; break; end
    end
    checkOutput("reach line 2", 0, found, 1);
    @(posedge clk);
    #2 enable = 1'b0;
    d0 = doneCnt[0];
    repeat (600) @(negedge clk);
    checkOutput("frames after drop", 0, doneCnt[0] - d0, 1);
    for (int g = 0; g < NDUT; g++) begin
      snapVs[g] = vsRiseCnt[g];
      snapDone[g] = doneCnt[g];
    end
    repeat (300) @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      checkOutput("idle vsync rises", g, vsRiseCnt[g], snapVs[g]);
      checkOutput("idle frame_done", g, doneCnt[g], snapDone[g]);
      checkOutput("idle vsync level", g, vsO[g], 0);
    end

    enable = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) checkOutput("restart vsync", g, vsO[g], 1);

    // Asynchronous reset in the middle of the active region
    found = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (hrefO[0]) begin found = 1; break; end
    end
    checkOutput("reach active", 0, found, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkAllZero("async reset");
    repeat (3) @(negedge clk);
    checkAllZero("held reset");
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) checkOutput("fresh frame vsync", g, vsO[g], 1);
    d1 = doneCnt[1];
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (doneCnt[1] >= d1 + 2) break;
    end
    checkOutput("fresh frames complete", 1, int'(doneCnt[1] >= d1 + 2), 1);
  endtask

  initial begin
    applyStimulus();
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
